// File: rtl/jk_excite_ctrl_pkg.sv
// Shared definitions for blocks that drive banks of external JK flip-flops:
// controller state encoding and the per-bit JK excitation table.
package jk_excite_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StCheck = 2'd2
    } state_e;

    // Excitation codes as {j, k}; toggle (2'b11) is deliberately never produced.
    localparam logic [1:0] JK_HOLD  = 2'b00;
    localparam logic [1:0] JK_SET   = 2'b10;
    localparam logic [1:0] JK_RESET = 2'b01;

    // Excitation for one bit moving from cur to tgt; don't-cares resolved to 0.
    function automatic logic [1:0] jk_excite_bit(input logic cur, input logic tgt);
        logic [1:0] code;
        unique case ({cur, tgt})
            2'b01:   code = JK_SET;
            2'b10:   code = JK_RESET;
            default: code = JK_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation for a WIDTH-wide bank: j/k move each bit from cur to tgt
// in one clock when en is high, and hold (j=k=0) otherwise.
module jk_excite
    import jk_excite_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic             en,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                {j[i], k[i]} = jk_excite_bit(cur[i], tgt[i]);
            end
        end
    end

endmodule

// File: rtl/jk_excite_ctrl.sv
// Drives an external JK register bank to a target word accepted over valid/ready,
// verifies the readback, retries up to MAX_RETRY times, and pulses done or err.
module jk_excite_ctrl
    import jk_excite_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             c,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic [RetryW-1:0]  retry_q, retry_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Reset has priority in the register, so ready is implied here.
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    retry_d = '0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                state_d = StCheck;
            end
            StCheck: begin
                if (q == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (retry_q < RetryMax) begin
                    retry_d = retry_q + 1'b1;
                    state_d = StDrive;
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    jk_excite #(
        .WIDTH (WIDTH)
    ) u_jk_excite (
        .cur (q),
        .tgt (tgt_q),
        .en  (state_q == StDrive),
        .j   (j),
        .k   (k)
    );

    assign busy      = (state_q != StIdle);
    assign tgt_ready = ~rst & (state_q == StIdle);
    assign done      = done_q;
    assign err       = err_q;

endmodule
